// File: rtl/book_pkg.sv
// Shared types for the order-book memory responder: entry layout, FSM states
// and the entry parity helper.
package book_pkg;

  typedef struct packed {
    logic [15:0] order_id;
    logic [15:0] price;
    logic [15:0] quantity;
    logic [0:0]  side;
  } book_entry;

  localparam int BOOK_DEPTH_DEFAULT = 128;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_t;

  // Even parity over every entry bit.
  function automatic logic entry_parity(input book_entry e);
    return ^e;
  endfunction

endpackage

// File: rtl/book_store.sv
// Book-entry storage: synchronous-write array, occupancy bitmap and, when
// BOOK_PARITY_EN is defined, a per-entry parity column.
module book_store
  import book_pkg::*;
#(
  parameter int DEPTH = BOOK_DEPTH_DEFAULT,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  book_entry     wdata,
  input  logic [AW-1:0] raddr,
  output book_entry     rdata,
  output logic          rocc,
  output logic          rpar_ok
);

  book_entry        mem_q [DEPTH];
  logic [DEPTH-1:0] occ_q;

  // Entry contents survive reset; only occupancy is cleared.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     occ_q        <= '0;
    else if (we) occ_q[waddr] <= 1'b1;
  end

  assign rdata = mem_q[raddr];
  assign rocc  = occ_q[raddr];

`ifdef BOOK_PARITY_EN
  logic par_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) par_q[waddr] <= entry_parity(wdata);
  end

  assign rpar_ok = (entry_parity(rdata) == par_q[raddr]);
`else
  assign rpar_ok = 1'b1;
`endif

endmodule

// File: rtl/book_mem_resp.sv
// Order-book memory responder: accepts one request at a time, answers with a
// one-cycle valid pulse LATENCY cycles later. Parity checking via BOOK_PARITY_EN.
module book_mem_resp
  import book_pkg::*;
#(
  parameter int DEPTH   = BOOK_DEPTH_DEFAULT,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_start,
  input  logic        is_write,
  input  logic [15:0] addr,
  input  book_entry   data_w,
  output logic        busy,
  output logic        valid,
  output book_entry   data_r,
  output logic        rd_empty,
  output logic        addr_err,
  output logic        parity_err
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH_L  = 17'(DEPTH);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  resp_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  book_entry   data_r_q, data_r_d;
  logic        rd_empty_q, rd_empty_d;
  logic        addr_err_q, addr_err_d;
  logic        parity_err_q, parity_err_d;

  logic        wr_q;
  logic [15:0] addr_q;
  book_entry   wdata_q;

  logic        accept, resp_now, addr_bad, store_we;
  book_entry   st_rdata;
  logic        st_rocc, st_rpar_ok;

  assign accept   = (state_q == IDLE) && mem_start;
  assign resp_now = (state_q == WAIT) && (cnt_q == 4'd0);
  assign addr_bad = ({1'b0, addr_q} >= DEPTH_L);
  assign store_we = resp_now && wr_q && !addr_bad;

  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q    <= is_write;
      addr_q  <= addr;
      wdata_q <= data_w;
    end
  end

  book_store #(.DEPTH(DEPTH), .AW(AW)) u_store (
    .clk     (clk),
    .rst     (rst),
    .we      (store_we),
    .waddr   (addr_q[AW-1:0]),
    .wdata   (wdata_q),
    .raddr   (addr_q[AW-1:0]),
    .rdata   (st_rdata),
    .rocc    (st_rocc),
    .rpar_ok (st_rpar_ok)
  );

  // WAIT always runs at least once, so valid lands exactly LATENCY edges
  // after the accepting edge for every legal LATENCY including 1.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    valid_d      = 1'b0;
    data_r_d     = '0;
    rd_empty_d   = 1'b0;
    addr_err_d   = 1'b0;
    parity_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_start) begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
          busy_d  = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          valid_d    = 1'b1;
          addr_err_d = addr_bad;
          if (!wr_q && !addr_bad) begin
            if (st_rocc) begin
              data_r_d     = st_rdata;
              parity_err_d = !st_rpar_ok;
            end else begin
              rd_empty_d = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      data_r_q     <= '0;
      rd_empty_q   <= 1'b0;
      addr_err_q   <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      valid_q      <= valid_d;
      data_r_q     <= data_r_d;
      rd_empty_q   <= rd_empty_d;
      addr_err_q   <= addr_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign busy       = busy_q;
  assign valid      = valid_q;
  assign data_r     = data_r_q;
  assign rd_empty   = rd_empty_q;
  assign addr_err   = addr_err_q;
  assign parity_err = parity_err_q;

endmodule

// File: tb/tb_book_mem_resp.sv
// Directed self-checking bench for book_mem_resp (DEPTH=128, LATENCY=2).
module tb_book_mem_resp;
  import book_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_start;
  logic        is_write;
  logic [15:0] addr;
  book_entry   data_w;
  logic        busy;
  logic        valid;
  book_entry   data_r;
  logic        rd_empty;
  logic        addr_err;
  logic        parity_err;

  int checks   = 0;
  int failures = 0;

  int        lat;
  book_entry r_dat;
  logic      r_emp, r_aerr, r_perr, r_bsy;
  int        vcount;

  book_entry e1, e2, e3, zero_e, e1_flip;

  always #5 clk = ~clk;

  book_mem_resp #(.DEPTH(128), .LATENCY(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_start  (mem_start),
    .is_write   (is_write),
    .addr       (addr),
    .data_w     (data_w),
    .busy       (busy),
    .valid      (valid),
    .data_r     (data_r),
    .rd_empty   (rd_empty),
    .addr_err   (addr_err),
    .parity_err (parity_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request for a single accepting edge, then capture the valid cycle.
  task automatic do_req(input logic wr, input logic [15:0] a, input book_entry d,
                        output int l, output book_entry rd, output logic emp,
                        output logic aerr, output logic perr, output logic bsy);
    @(negedge clk);
    mem_start = 1'b1; is_write = wr; addr = a; data_w = d;
    @(posedge clk);
    #1 mem_start = 1'b0;
    l = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      l++;
      if (valid) break;
    end
    if (!valid) l = 99;
    rd = data_r; emp = rd_empty; aerr = addr_err; perr = parity_err; bsy = busy;
    @(posedge clk); #1;
    chk("pulse_one_cycle", {63'b0, valid}, 64'd0);
    chk("busy_released", {63'b0, busy}, 64'd0);
  endtask

  initial begin
    e1     = '{order_id: 16'h0011, price: 16'd1000, quantity: 16'd50, side: 1'b0};
    e2     = '{order_id: 16'h0A0B, price: 16'd777,  quantity: 16'd3,  side: 1'b1};
    e3     = '{order_id: 16'hBEEF, price: 16'd42,   quantity: 16'd9,  side: 1'b1};
    zero_e = '0;
    e1_flip = e1;
    e1_flip.price[0] = ~e1.price[0];

    rst = 1'b1; mem_start = 1'b0; is_write = 1'b0; addr = '0; data_w = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_valid", {63'b0, valid}, 64'd0);
    chk("rst_data_r", 64'(data_r), 64'd0);
    chk("rst_flags", {61'b0, rd_empty, addr_err, parity_err}, 64'd0);
    @(negedge clk) rst = 1'b0;

    // Write then read back slot 5
    do_req(1'b1, 16'd5, e1, lat, r_dat, r_emp, r_aerr, r_perr, r_bsy);
    chk("wr5_latency", 64'(lat), 64'd2);
    chk("wr5_busy_in_valid", {63'b0, r_bsy}, 64'd1);
    chk("wr5_data_r", 64'(r_dat), 64'd0);
    chk("wr5_flags", {61'b0, r_emp, r_aerr, r_perr}, 64'd0);

    do_req(1'b0, 16'd5, zero_e, lat, r_dat, r_emp, r_aerr, r_perr, r_bsy);
    chk("rd5_latency", 64'(lat), 64'd2);
    chk("rd5_data", 64'(r_dat), 64'(e1));
    chk("rd5_flags", {61'b0, r_emp, r_aerr, r_perr}, 64'd0);

    // Never-written slot
    do_req(1'b0, 16'd7, zero_e, lat, r_dat, r_emp, r_aerr, r_perr, r_bsy);
    chk("rd7_latency", 64'(lat), 64'd2);
    chk("rd7_data", 64'(r_dat), 64'd0);
    chk("rd7_empty", {63'b0, r_emp}, 64'd1);
    chk("rd7_aerr", {63'b0, r_aerr}, 64'd0);

    // Out-of-range write must not alias onto 200 & 127 = 72
    do_req(1'b1, 16'd200, e3, lat, r_dat, r_emp, r_aerr, r_perr, r_bsy);
    chk("wr200_latency", 64'(lat), 64'd2);
    chk("wr200_aerr", {63'b0, r_aerr}, 64'd1);
    do_req(1'b0, 16'd72, zero_e, lat, r_dat, r_emp, r_aerr, r_perr, r_bsy);
    chk("rd72_empty", {63'b0, r_emp}, 64'd1);
    chk("rd72_aerr", {63'b0, r_aerr}, 64'd0);
    chk("rd72_data", 64'(r_dat), 64'd0);
    do_req(1'b0, 16'd200, zero_e, lat, r_dat, r_emp, r_aerr, r_perr, r_bsy);
    chk("rd200_aerr", {63'b0, r_aerr}, 64'd1);
    chk("rd200_empty", {63'b0, r_emp}, 64'd0);
    chk("rd200_data", 64'(r_dat), 64'd0);
    do_req(1'b0, 16'd128, zero_e, lat, r_dat, r_emp, r_aerr, r_perr, r_bsy);
    chk("rd128_aerr", {63'b0, r_aerr}, 64'd1);
    do_req(1'b0, 16'd127, zero_e, lat, r_dat, r_emp, r_aerr, r_perr, r_bsy);
    chk("rd127_aerr", {63'b0, r_aerr}, 64'd0);
    chk("rd127_empty", {63'b0, r_emp}, 64'd1);

    // mem_start held through busy with a different address
    @(negedge clk);
    mem_start = 1'b1; is_write = 1'b1; addr = 16'd20; data_w = e2;
    @(posedge clk);
    #1 addr = 16'd21; data_w = e3;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (valid) break;
    end
    if (!valid) lat = 99;
    mem_start = 1'b0;
    chk("hold_latency", 64'(lat), 64'd2);
    vcount = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (valid) vcount++;
    end
    chk("hold_single_valid", 64'(vcount), 64'd0);
    do_req(1'b0, 16'd20, zero_e, lat, r_dat, r_emp, r_aerr, r_perr, r_bsy);
    chk("hold_rd20_data", 64'(r_dat), 64'(e2));
    do_req(1'b0, 16'd21, zero_e, lat, r_dat, r_emp, r_aerr, r_perr, r_bsy);
    chk("hold_rd21_empty", {63'b0, r_emp}, 64'd1);

    // Reset while a write to slot 3 is waiting
    @(negedge clk);
    mem_start = 1'b1; is_write = 1'b1; addr = 16'd3; data_w = e2;
    @(posedge clk);
    #1 mem_start = 1'b0; rst = 1'b1;
    #1;
    chk("midrst_busy", {63'b0, busy}, 64'd0);
    chk("midrst_valid", {63'b0, valid}, 64'd0);
    vcount = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (valid) vcount++;
    end
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (valid) vcount++;
    end
    chk("midrst_no_valid", 64'(vcount), 64'd0);
    do_req(1'b0, 16'd3, zero_e, lat, r_dat, r_emp, r_aerr, r_perr, r_bsy);
    chk("midrst_rd3_empty", {63'b0, r_emp}, 64'd1);
    // Slot 5 content and occupancy: occupancy was cleared, so it reads empty
    do_req(1'b0, 16'd5, zero_e, lat, r_dat, r_emp, r_aerr, r_perr, r_bsy);
    chk("midrst_rd5_empty", {63'b0, r_emp}, 64'd1);

    // Back-to-back write then read of slot 9, then parity behaviour
    do_req(1'b1, 16'd9, e1, lat, r_dat, r_emp, r_aerr, r_perr, r_bsy);
    chk("wr9_latency", 64'(lat), 64'd2);
    do_req(1'b0, 16'd9, zero_e, lat, r_dat, r_emp, r_aerr, r_perr, r_bsy);
    chk("rd9_data", 64'(r_dat), 64'(e1));
    chk("rd9_perr_clean", {63'b0, r_perr}, 64'd0);
`ifdef BOOK_PARITY_EN
    dut.u_store.mem_q[9] = e1_flip;
    do_req(1'b0, 16'd9, zero_e, lat, r_dat, r_emp, r_aerr, r_perr, r_bsy);
    chk("rd9_flip_perr", {63'b0, r_perr}, 64'd1);
    chk("rd9_flip_data", 64'(r_dat), 64'(e1_flip));
`else
    do_req(1'b0, 16'd9, zero_e, lat, r_dat, r_emp, r_aerr, r_perr, r_bsy);
    chk("rd9_noparity_perr", {63'b0, r_perr}, 64'd0);
    chk("rd9_noparity_data", 64'(r_dat), 64'(e1));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
